ori_pixel_gen: RTL and testbench

//  Parametrised pixel serializer for the Orion video path, successor to the fixed 8-bit pixel unit.
//  - Pulls {colour,pixel} plane words from the video fetch unit over a req/ack handshake.
//  - Holds one staged word and shifts it out one pixel per dot enable; supports horizontal pixel doubling.
//  - Maps pixels to colour indices through a CPU-writable 16-entry palette. Feeds the DAC/sync stage.

---
 rtl/ori_video_pkg.sv | 44 ++++
 rtl/ori_pixel_gen_if.sv | 13 +
 rtl/ori_palette_ram.sv | 32 +++
 rtl/ori_pixel_gen.sv | 161 ++++++++++++++++
 tb/tb_ori_pixel_gen.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ori_video_pkg.sv
// Shared types and constants for the Orion pixel serializer.
package ori_video_pkg;

    // Video modes as presented on vmode_i.
    typedef enum logic [2:0] {
        VMODE_2C_P1  = 3'd0,
        VMODE_2C_P2  = 3'd1,
        VMODE_BLK_A  = 3'd2,
        VMODE_BLK_B  = 3'd3,
        VMODE_4C_P1  = 3'd4,
        VMODE_4C_P2  = 3'd5,
        VMODE_16C_A  = 3'd6,
        VMODE_16C_B  = 3'd7
    } vmode_e;

    // Fetch handshake states.
    typedef enum logic {
        FS_REQ  = 1'b0,
        FS_FULL = 1'b1
    } fetch_state_e;

    // Palette contents after reset; element [i] is entry i.
    localparam logic [15:0][3:0] PAL_RESET = {
        4'h0, 4'h0, 4'h0, 4'h0,
        4'h5, 4'h6, 4'h7, 4'h3,
        4'h1, 4'h2, 4'h4, 4'h0,
        4'hE, 4'h9, 4'h2, 4'h0
    };

    // Palette index for the palette-based modes; other modes return 0.
    function automatic logic [3:0] pal_index(input vmode_e m, input logic p, input logic c);
        logic [3:0] idx;
        idx = 4'h0;
        case (m)
            VMODE_2C_P1: idx = {3'b000, p};
            VMODE_2C_P2: idx = {3'b001, p};
            VMODE_4C_P1: idx = {2'b01, p, c};
            VMODE_4C_P2: idx = {2'b10, p, c};
            default:     idx = 4'h0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/ori_pixel_gen_if.sv
// Plane-word fetch handshake between the pixel serializer and the video fetch unit.
interface ori_pixel_gen_if #(
    parameter int unsigned DW = 8
) ();
    logic              req;
    logic              ack;
    logic [2*DW-1:0]   data;

    // Serializer side: raises req, receives ack/data.
    modport master (output req, input ack, input data);
    // Fetch unit side: answers req with ack/data.
    modport slave  (input req, output ack, output data);
endinterface

// File: rtl/ori_palette_ram.sv
// 16-entry CPU-writable colour palette, asynchronous read, reset to PAL_RESET.
module ori_palette_ram
    import ori_video_pkg::*;
#(
    parameter int unsigned OUT_W = 4
) (
    input  logic             clk_i,
    input  logic             por_ni,
    input  logic             we_i,
    input  logic [3:0]       waddr_i,
    input  logic [OUT_W-1:0] wdata_i,
    input  logic [3:0]       raddr_i,
    output logic [OUT_W-1:0] rdata_o
);

    logic [OUT_W-1:0] r_mem [16];

    // Register file: reset table on por, single write port.
    always_ff @(posedge clk_i or negedge por_ni) begin
        if (!por_ni) begin
            for (int unsigned i = 0; i < 16; i++) begin
                r_mem[i[3:0]] <= OUT_W'(PAL_RESET[i[3:0]]);
            end
        end else if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    // Read sees the pre-write value during a write cycle.
    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/ori_pixel_gen.sv
// Orion pixel serializer: fetch staging, pixel/colour shifters, palette mapping.
module ori_pixel_gen
    import ori_video_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned OUT_W = 4
) (
    input  logic                  clk_i,
    input  logic                  por_ni,
    input  logic                  cke_dot_i,
    input  logic                  load_i,
    input  logic                  hdouble_i,
    input  logic                  blank_i,
    input  logic [2:0]            vmode_i,
    ori_pixel_gen_if.master       fetch,
    input  logic                  pal_we_i,
    input  logic [3:0]            pal_addr_i,
    input  logic [OUT_W-1:0]      pal_data_i,
    input  logic                  urun_clr_i,
    output logic [OUT_W-1:0]      pix_col_o,
    output logic                  underrun_o
);

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic [2*DW-1:0]  r_stg;
    logic [DW-1:0]    r_pix_sh;
    logic [DW-1:0]    r_col_sh;
    logic [DW-1:0]    r_col_hold;
    logic             r_phase;
    logic             r_underrun;
    logic [OUT_W-1:0] r_pix_col;

    logic             w_req;
    logic             w_stg_we;
    logic             w_sh_load;
    logic [2*DW-1:0]  w_sh_data;
    logic             w_urun_set;
    vmode_e           w_vmode;
    logic             w_p;
    logic             w_c;
    logic [3:0]       w_pal_idx;
    logic [OUT_W-1:0] w_pal_rd;
    logic [OUT_W-1:0] w_col_nxt;

    // Fetch FSM state register.
    always_ff @(posedge clk_i or negedge por_ni) begin
        if (!por_ni) r_state <= FS_REQ;
        else         r_state <= w_state_nxt;
    end

    // Fetch FSM next state, staging write and shifter load source.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_stg_we    = 1'b0;
        w_sh_load   = 1'b0;
        w_sh_data   = '0;
        w_urun_set  = 1'b0;
        case (r_state)
            FS_REQ: begin
                w_req = 1'b1;
                if (load_i) begin
                    // A load while still requesting either bypasses the arriving word
                    // straight into the shifters or loads zeros as an underrun.
                    w_sh_load = 1'b1;
                    if (fetch.ack) w_sh_data = fetch.data;
                    else           w_urun_set = 1'b1;
                end else if (fetch.ack) begin
                    w_stg_we    = 1'b1;
                    w_state_nxt = FS_FULL;
                end
            end
            FS_FULL: begin
                if (load_i) begin
                    w_sh_load   = 1'b1;
                    w_sh_data   = r_stg;
                    w_state_nxt = FS_REQ;
                end
            end
            default: w_state_nxt = FS_REQ;
        endcase
    end

    assign fetch.req = w_req;

    // Staging word capture on an accepted fetch.
    always_ff @(posedge clk_i or negedge por_ni) begin
        if (!por_ni)       r_stg <= '0;
        else if (w_stg_we) r_stg <= fetch.data;
    end

    // Shifters and doubling phase; a cell load beats a same-cycle shift.
    always_ff @(posedge clk_i or negedge por_ni) begin
        if (!por_ni) begin
            r_pix_sh   <= '0;
            r_col_sh   <= '0;
            r_col_hold <= '0;
            r_phase    <= 1'b0;
        end else if (w_sh_load) begin
            r_pix_sh   <= w_sh_data[DW-1:0];
            r_col_sh   <= w_sh_data[2*DW-1:DW];
            r_col_hold <= w_sh_data[2*DW-1:DW];
            r_phase    <= 1'b0;
        end else if (cke_dot_i) begin
            if (!hdouble_i || r_phase) begin
                r_pix_sh <= {r_pix_sh[DW-2:0], 1'b0};
                r_col_sh <= {r_col_sh[DW-2:0], 1'b0};
            end
            r_phase <= ~r_phase;
        end
    end

    // Sticky underrun flag; set wins over clear.
    always_ff @(posedge clk_i or negedge por_ni) begin
        if (!por_ni)         r_underrun <= 1'b0;
        else if (w_urun_set) r_underrun <= 1'b1;
        else if (urun_clr_i) r_underrun <= 1'b0;
    end

    assign w_vmode   = vmode_e'(vmode_i);
    assign w_p       = r_pix_sh[DW-1];
    assign w_c       = r_col_sh[DW-1];
    assign w_pal_idx = pal_index(w_vmode, w_p, w_c);

    ori_palette_ram #(
        .OUT_W (OUT_W)
    ) u_pal (
        .clk_i   (clk_i),
        .por_ni  (por_ni),
        .we_i    (pal_we_i),
        .waddr_i (pal_addr_i),
        .wdata_i (pal_data_i),
        .raddr_i (w_pal_idx),
        .rdata_o (w_pal_rd)
    );

    // Colour mapper: palette modes, direct 16-colour modes, blanking.
    always_comb begin
        w_col_nxt = '0;
        if (!blank_i) begin
            case (w_vmode)
                VMODE_2C_P1, VMODE_2C_P2,
                VMODE_4C_P1, VMODE_4C_P2: w_col_nxt = w_pal_rd;
                VMODE_16C_A, VMODE_16C_B: w_col_nxt = w_p ? r_col_hold[OUT_W-1:0]
                                                          : OUT_W'(r_col_hold >> OUT_W);
                default:                  w_col_nxt = '0;
            endcase
        end
    end

    // Registered colour output.
    always_ff @(posedge clk_i or negedge por_ni) begin
        if (!por_ni) r_pix_col <= '0;
        else         r_pix_col <= w_col_nxt;
    end

    assign pix_col_o  = r_pix_col;
    assign underrun_o = r_underrun;

endmodule

// File: tb/tb_ori_pixel_gen.sv
// Directed self-checking bench for ori_pixel_gen.
module tb_ori_pixel_gen;

    localparam int unsigned DW    = 8;
    localparam int unsigned OUT_W = 4;

    logic             clk_i      = 1'b0;
    logic             por_ni     = 1'b0;
    logic             cke_dot_i  = 1'b0;
    logic             load_i     = 1'b0;
    logic             hdouble_i  = 1'b0;
    logic             blank_i    = 1'b0;
    logic [2:0]       vmode_i    = '0;
    logic             pal_we_i   = 1'b0;
    logic [3:0]       pal_addr_i = '0;
    logic [OUT_W-1:0] pal_data_i = '0;
    logic             urun_clr_i = 1'b0;
    logic [OUT_W-1:0] pix_col_o;
    logic             underrun_o;

    int n_cmp = 0;
    int n_err = 0;

    ori_pixel_gen_if #(.DW(DW)) u_if ();

    ori_pixel_gen #(
        .DW    (DW),
        .OUT_W (OUT_W)
    ) u_dut (
        .clk_i      (clk_i),
        .por_ni     (por_ni),
        .cke_dot_i  (cke_dot_i),
        .load_i     (load_i),
        .hdouble_i  (hdouble_i),
        .blank_i    (blank_i),
        .vmode_i    (vmode_i),
        .fetch      (u_if),
        .pal_we_i   (pal_we_i),
        .pal_addr_i (pal_addr_i),
        .pal_data_i (pal_data_i),
        .urun_clr_i (urun_clr_i),
        .pix_col_o  (pix_col_o),
        .underrun_o (underrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic fetch_word(input logic [2*DW-1:0] d);
        u_if.ack  = 1'b1;
        u_if.data = d;
        tick();
        u_if.ack  = 1'b0;
        u_if.data = '0;
    endtask

    task automatic load_cell();
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
    endtask

    // Runs n dots; nibble i of the expected sequence is seq[4*(n-1-i) +: 4].
    task automatic expect_dots(input string tag, input int unsigned n, input logic [63:0] seq);
        cke_dot_i = 1'b1;
        for (int unsigned i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s_dot%0d", tag, i), 32'(pix_col_o), 32'(seq[4*(n-1-i) +: 4]));
        end
        cke_dot_i = 1'b0;
    endtask

    initial begin
        u_if.ack  = 1'b0;
        u_if.data = '0;
        #2;
        chk("rst_req", 32'(u_if.req), 32'd1);
        chk("rst_pix", 32'(pix_col_o), 32'd0);
        chk("rst_urun", 32'(underrun_o), 32'd0);
        #10;
        por_ni = 1'b1;
        tick();

        // 1: basic 2-colour cell
        fetch_word(16'hA5F0);
        chk("t1_req_full", 32'(u_if.req), 32'd0);
        vmode_i = 3'd0;
        load_cell();
        chk("t1_req_again", 32'(u_if.req), 32'd1);
        expect_dots("t1", 8, 64'h2222_0000);

        // 2: 4-colour modes; an ack while staged is ignored
        vmode_i = 3'd4;
        fetch_word(16'hA0C0);
        fetch_word(16'h0000);
        load_cell();
        expect_dots("t2m4", 8, 64'h1240_0000);
        vmode_i = 3'd5;
        fetch_word(16'hA0C0);
        load_cell();
        expect_dots("t2m5", 8, 64'h5673_3333);

        // 3: underrun loads zeros, clear, set beats clear
        fetch_word(16'hFFFF);
        load_cell();
        expect_dots("t3_pre", 2, 64'h55);
        load_cell();
        chk("t3_urun_set", 32'(underrun_o), 32'd1);
        expect_dots("t3_zero", 3, 64'h333);
        urun_clr_i = 1'b1;
        tick();
        urun_clr_i = 1'b0;
        chk("t3_urun_clr", 32'(underrun_o), 32'd0);
        urun_clr_i = 1'b1;
        load_i     = 1'b1;
        tick();
        load_i     = 1'b0;
        urun_clr_i = 1'b0;
        chk("t3_set_wins", 32'(underrun_o), 32'd1);
        urun_clr_i = 1'b1;
        tick();
        urun_clr_i = 1'b0;
        chk("t3_clr2", 32'(underrun_o), 32'd0);

        // 4: load and ack together in REQ -> bypass
        vmode_i   = 3'd0;
        load_i    = 1'b1;
        u_if.ack  = 1'b1;
        u_if.data = 16'h0080;
        tick();
        load_i    = 1'b0;
        u_if.ack  = 1'b0;
        u_if.data = '0;
        chk("t4_no_urun", 32'(underrun_o), 32'd0);
        chk("t4_req", 32'(u_if.req), 32'd1);
        expect_dots("t4", 3, 64'h200);

        // 5: pixel doubling, load coincident with a dot
        hdouble_i = 1'b1;
        fetch_word(16'h0080);
        load_cell();
        expect_dots("t5", 16, 64'h2200_0000_0000_0000);
        fetch_word(16'h0080);
        cke_dot_i = 1'b1;
        load_cell();
        expect_dots("t5_ldwin", 4, 64'h2200);
        hdouble_i = 1'b0;

        // 6: palette write, read-during-write, 16-colour, blank, blank mode
        pal_we_i   = 1'b1;
        pal_addr_i = 4'd1;
        pal_data_i = 4'hF;
        tick();
        pal_we_i   = 1'b0;
        fetch_word(16'h00FF);
        load_cell();
        expect_dots("t6_pal", 8, 64'hFFFF_FFFF);
        fetch_word(16'h00FF);
        load_cell();
        cke_dot_i  = 1'b1;
        pal_we_i   = 1'b1;
        pal_data_i = 4'h9;
        tick();
        pal_we_i   = 1'b0;
        chk("t6_rdw_old", 32'(pix_col_o), 32'hF);
        tick();
        cke_dot_i  = 1'b0;
        chk("t6_rdw_new", 32'(pix_col_o), 32'h9);
        vmode_i = 3'd6;
        fetch_word(16'h3CF0);
        load_cell();
        expect_dots("t6_m6", 8, 64'hCCCC_3333);
        vmode_i = 3'd7;
        fetch_word(16'h3CF0);
        load_cell();
        expect_dots("t6_m7", 4, 64'hCCCC);
        blank_i = 1'b1;
        expect_dots("t6_blank", 4, 64'h0000);
        blank_i = 1'b0;
        vmode_i = 3'd2;
        fetch_word(16'hFFFF);
        load_cell();
        expect_dots("t6_m2", 2, 64'h00);

        // 7: asynchronous reset mid-cell restores everything
        vmode_i = 3'd0;
        load_cell();
        chk("t7_urun_pre", 32'(underrun_o), 32'd1);
        fetch_word(16'hFFFF);
        chk("t7_req_pre", 32'(u_if.req), 32'd0);
        #2;
        por_ni = 1'b0;
        #1;
        chk("t7_rst_req", 32'(u_if.req), 32'd1);
        chk("t7_rst_urun", 32'(underrun_o), 32'd0);
        chk("t7_rst_pix", 32'(pix_col_o), 32'd0);
        #2;
        por_ni = 1'b1;
        tick();
        fetch_word(16'h00FF);
        load_cell();
        expect_dots("t7_palrst", 2, 64'h22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
